// File: rtl/axis_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_pkg
// Shared sizing helpers and default widths for the AXI4-Stream synchronous FIFO.
//   fifo_cnt_w(depth)            : width of a 0..depth occupancy counter
//   beat_w(tdata,tid,tdest,tuser): width of one packed FIFO entry
//                                  (tdata + tkeep + tstrb + tid + tdest + tuser + tlast)
// -----------------------------------------------------------------------------
package axis_sync_fifo_pkg;

    localparam int TDATA_WIDTH_DEF   = 32;
    localparam int TID_WIDTH_DEF     = 1;
    localparam int TDEST_WIDTH_DEF   = 1;
    localparam int TUSER_WIDTH_DEF   = 1;
    localparam int DEPTH_DEF         = 16;
    localparam int ALMOST_FULL_DEF   = 14;

    // One extra bit so the counter can represent "completely full".
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int beat_w(input int tdata_w, input int tid_w,
                                  input int tdest_w, input int tuser_w);
        return tdata_w + 2 * (tdata_w / 8) + tid_w + tdest_w + tuser_w + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_ram
// Simple dual-port storage: synchronous write, asynchronous read.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data (one packed beat)
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module axis_sync_fifo_ram
    import axis_sync_fifo_pkg::*;
#(
    parameter int DEPTH_P = DEPTH_DEF,
    parameter int WIDTH_P = 8
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH_P)-1:0] waddr_i,
    input  logic [WIDTH_P-1:0]         wdata_i,
    input  logic [$clog2(DEPTH_P)-1:0] raddr_i,
    output logic [WIDTH_P-1:0]         rdata_o
);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers
    // and fill counter, and a reset-free array maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock first-word-fall-through AXI4-Stream FIFO carrying tdata, tkeep,
// tstrb, tid, tdest, tuser and tlast, with a registered fill level and
// almost-full flag.
//
// Build option: define AXIS_SYNC_FIFO_PACKET_MODE_EN for store-and-forward
// operation (m_axis_tvalid held off until a whole packet is stored, or the
// FIFO is full, in which case the packet streams cut-through).
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   s_axis_*            : upstream slave interface (tready registered)
//   m_axis_*            : downstream master interface
//   fill_level          : number of stored beats, 0..DEPTH_P
//   almost_full         : registered, fill_level >= ALMOST_FULL_P
// -----------------------------------------------------------------------------
module axis_sync_fifo
    import axis_sync_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH_P = TDATA_WIDTH_DEF,
    parameter int TID_WIDTH_P   = TID_WIDTH_DEF,
    parameter int TDEST_WIDTH_P = TDEST_WIDTH_DEF,
    parameter int TUSER_WIDTH_P = TUSER_WIDTH_DEF,
    parameter int DEPTH_P       = DEPTH_DEF,
    parameter int ALMOST_FULL_P = ALMOST_FULL_DEF
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [TDATA_WIDTH_P-1:0]          s_axis_tdata,
    input  logic [TDATA_WIDTH_P/8-1:0]        s_axis_tkeep,
    input  logic [TDATA_WIDTH_P/8-1:0]        s_axis_tstrb,
    input  logic [TID_WIDTH_P-1:0]            s_axis_tid,
    input  logic [TDEST_WIDTH_P-1:0]          s_axis_tdest,
    input  logic [TUSER_WIDTH_P-1:0]          s_axis_tuser,
    input  logic                              s_axis_tlast,

    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [TDATA_WIDTH_P-1:0]          m_axis_tdata,
    output logic [TDATA_WIDTH_P/8-1:0]        m_axis_tkeep,
    output logic [TDATA_WIDTH_P/8-1:0]        m_axis_tstrb,
    output logic [TID_WIDTH_P-1:0]            m_axis_tid,
    output logic [TDEST_WIDTH_P-1:0]          m_axis_tdest,
    output logic [TUSER_WIDTH_P-1:0]          m_axis_tuser,
    output logic                              m_axis_tlast,

    output logic [fifo_cnt_w(DEPTH_P)-1:0]    fill_level,
    output logic                              almost_full
);

    localparam int PTR_W  = $clog2(DEPTH_P);
    localparam int CNT_W  = fifo_cnt_w(DEPTH_P);
    localparam int BEAT_W = beat_w(TDATA_WIDTH_P, TID_WIDTH_P, TDEST_WIDTH_P, TUSER_WIDTH_P);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_P);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(ALMOST_FULL_P);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_q,   fill_d;
    logic              s_tready_q;
    logic              almost_full_q;
    logic [BEAT_W-1:0] hold_q;

    logic              wr_fire;
    logic              rd_fire;
    logic              m_tvalid_w;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] ram_rdata;
    logic [BEAT_W-1:0] out_beat;

    // ------------------------------------------------------------------
    // Beat packing and storage
    // ------------------------------------------------------------------
    assign wr_beat = {s_axis_tlast, s_axis_tuser, s_axis_tdest, s_axis_tid,
                      s_axis_tstrb, s_axis_tkeep, s_axis_tdata};

    axis_sync_fifo_ram #(
        .DEPTH_P (DEPTH_P),
        .WIDTH_P (BEAT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // When empty, the RAM head points at a stale slot; present the last
    // beat that left the FIFO instead so the payload stays put.
    assign out_beat = (fill_q == '0) ? hold_q : ram_rdata;

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdest, m_axis_tid,
            m_axis_tstrb, m_axis_tkeep, m_axis_tdata} = out_beat;

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            hold_q <= ram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign wr_fire = s_axis_tvalid && s_tready_q;
    assign rd_fire = m_tvalid_w && m_axis_tready;

`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
    // Store-and-forward: release data only when a complete packet is held,
    // when the FIFO is full (oversized packet), or while an oversized packet
    // is already streaming out (cut_q), so valid never drops mid-packet.
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             cut_q, cut_d;
    logic             wr_last;
    logic             rd_last;

    assign wr_last = wr_fire && s_axis_tlast;
    assign rd_last = rd_fire && m_axis_tlast;

    assign m_tvalid_w = (fill_q != '0) &&
                        ((pkt_cnt_q != '0) || (fill_q == DEPTH_CNT) || cut_q);

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        cut_d     = cut_q;
        case ({wr_last, rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        if (rd_fire) begin
            if (rd_last) begin
                cut_d = 1'b0;
            end else if (pkt_cnt_q == '0) begin
                cut_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            cut_q     <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            cut_q     <= cut_d;
        end
    end
`else
    assign m_tvalid_w = (fill_q != '0);
`endif

    // ------------------------------------------------------------------
    // Pointer and occupancy update
    // ------------------------------------------------------------------
    // NOTE: always_comb assigns every output a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   fill_d = fill_q + CNT_W'(1);
            2'b01:   fill_d = fill_q - CNT_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Ready and almost_full are computed from the next fill value so both
    // are registered yet accurate in the cycle they are presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            s_tready_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            s_tready_q    <= (fill_d < DEPTH_CNT);
            almost_full_q <= (fill_d >= AF_CNT);
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_w;
    assign fill_level    = fill_q;
    assign almost_full   = almost_full_q;

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
Parametrised single-clock AXI4-Stream FIFO carrying the full sideband set: tdata, tkeep, tstrb, tid, tdest, tuser and tlast. It sits between image-processing stages to absorb bursts and decouple backpressure. Widths are configurable, depth is configurable, and a fill level and almost-full flag are provided for flow control. An optional store-and-forward packet mode releases only whole frames or lines.

Parameters:
TDATA_WIDTH_P, 32, data width in bits; multiple of 8
TID_WIDTH_P, 1, tid width
TDEST_WIDTH_P, 1, tdest width
TUSER_WIDTH_P, 1, tuser width
DEPTH_P, 16, entry count; power of 2, >= 2
ALMOST_FULL_P, 14, fill level at or above which almost_full asserts; range 1..DEPTH_P

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_axis_tvalid  in  1  slave valid
s_axis_tready  out  1  slave ready
s_axis_tdata  in  TDATA_WIDTH_P  slave data
s_axis_tkeep  in  TDATA_WIDTH_P/8  slave keep
s_axis_tstrb  in  TDATA_WIDTH_P/8  slave strobe
s_axis_tid  in  TID_WIDTH_P  slave id
s_axis_tdest  in  TDEST_WIDTH_P  slave dest
s_axis_tuser  in  TUSER_WIDTH_P  slave user
s_axis_tlast  in  1  slave last
m_axis_*  out (tready in)  same widths  master mirror of all s_axis signals
fill_level  out  $clog2(DEPTH_P)+1  number of stored beats
almost_full  out  1  fill_level >= ALMOST_FULL_P

Behaviour:
- Reset:
  - Reset is asynchronous, active-high, on port rst; single clock clk.
  - While rst is high: s_axis_tready=0, m_axis_tvalid=0, fill_level=0, almost_full=0, read/write pointers=0.
  - m_axis payload outputs are don't-care while rst is high.
  - Asserting rst mid-operation discards all contents; any partial packet is lost.
  - s_axis_tready=1 from the first clock edge after rst deasserts.
- Write: on a clock edge with s_axis_tvalid && s_axis_tready, the beat is stored at wr_ptr and wr_ptr increments modulo DEPTH_P.
- Read: on a clock edge with m_axis_tvalid && m_axis_tready, rd_ptr increments modulo DEPTH_P.
- Ready and valid:
  - s_axis_tready = (fill_level < DEPTH_P). It is registered and has no combinational path from m_axis_tready.
  - m_axis_tvalid = (fill_level != 0) in normal mode.
- Latency and ordering:
  - First-word fall-through: a beat written at edge N is presented on m_axis in the cycle after edge N. Minimum latency is 1 cycle.
  - Beats are never reordered, and all sidebands travel with their beat.
- Full: s_axis_tready=0. A read at full frees one entry, and s_axis_tready rises the next cycle.
- Empty: m_axis_tvalid=0 and the payload is held at its last value.
- Simultaneous read and write: fill_level is unchanged. This holds at both non-empty and non-full boundaries.
- Pointers are $clog2(DEPTH_P) bits and wrap naturally. fill_level is a separate registered counter.
- almost_full is registered and is recomputed from the next value of fill_level.
- AXI rule: once m_axis_tvalid is high it stays high, with a stable payload, until accepted. The block relies on the upstream honouring the same rule.

Optional Feature:
- Macro: AXIS_SYNC_FIFO_PACKET_MODE_EN.
- Defined (store-and-forward):
  - A packet counter counts tlast beats stored.
    - +1 on a write of a tlast beat.
    - -1 on a read of a tlast beat.
    - Both in the same cycle: no change.
  - m_axis_tvalid = (fill_level != 0) && (pkt_cnt != 0 || fill_level == DEPTH_P).
  - The full override prevents deadlock on packets longer than DEPTH_P; such a packet then streams cut-through.
  - Once m_axis_tvalid is asserted it holds until the tlast read completes.
  - Reset clears pkt_cnt.
- Undefined: plain cut-through as described in Behaviour. No pkt_cnt logic is generated.

Decomposition:
- Package axis_sync_fifo_pkg holds:
  - function fifo_cnt_w(depth) returning $clog2(depth)+1;
  - function beat_w(tdata, tid, tdest, tuser) giving the packed entry width (tdata + 2*tdata/8 + tid + tdest + tuser + 1);
  - default-width localparams.
- Sub-module axis_sync_fifo_ram: simple dual-port, synchronous write, asynchronous read, DEPTH_P x beat_w. The parent packs and unpacks the sidebands.

Test Plan:
1. Reset then idle → s_axis_tready=1 one edge after rst falls; m_axis_tvalid=0; fill_level=0.
2. Write 16 beats (tdata=0..15, tuser=i[0], tlast on beat 15) with m_axis_tready=0 → fill_level=16, s_axis_tready=0, almost_full=1 from fill 14. Then drain → beats 0..15 in order with sidebands intact.
3. Continuous stream, both tready=1, 100 beats → throughput 1 beat/cycle, fill_level stays at 1, latency 1 cycle.
4. Random tvalid/tready at 50% each, 1000 beats with scoreboard → no loss, duplication or reorder; m_axis payload stable while tvalid && !tready.
5. Reset asserted with fill_level=7 → outputs reach reset values immediately; after release the FIFO is empty and old data never appears.
6. PACKET_MODE_EN, 4-beat packet, tlast late → m_axis_tvalid=0 until the cycle after the tlast write. A 20-beat packet with DEPTH_P=16 → tvalid rises at fill 16 and there is no deadlock.
